// File: rtl/irq_encoder8to3_pkg.sv
// Shared constants, FSM state type and code-to-mask helper for the 8-to-3 IRQ encoder.
package enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_OFFER = 1'b1
  } enc_state_t;

  // Re-expands a code into its request-line mask, matching the downstream 3-to-8 decoder.
  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] c);
    return N_REQ'(1) << c;
  endfunction

endpackage

// File: rtl/irq_encoder8to3_if.sv
// Valid/ready code handshake between the IRQ encoder (master) and its consumer (slave).
interface irq_encoder8to3_if;
  import enc_pkg::*;

  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;

  modport master (output code, output valid, input ready);
  modport slave  (input code, input valid, output ready);

endinterface

// File: rtl/irq_encoder8to3_prio.sv
// Combinational 8-input priority encoder; LOW_FIRST selects whether index 0 or 7 wins.
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Scan toward the winning end so the last hit is the highest-priority index.
  always_comb begin
    code = '0;
    any  = |vec;
    if (LOW_FIRST) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_encoder8to3.sv
// Sequential 8-to-3 priority encoder: latches requests, offers the top pending index over valid/ready.
// Optional sticky lost-request flag built when IRQ_ENCODER_OVF_EN is defined.
module irq_encoder8to3
  import enc_pkg::*;
#(
  parameter bit LOW_FIRST   = 1'b0,
  parameter bit EDGE_DETECT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  irq_encoder8to3_if.master hs,
  output logic [N_REQ-1:0]  pending,
  output logic              ovf
);

  enc_state_t        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [N_REQ-1:0]  req_d;
  logic [N_REQ-1:0]  rise, set, clr, rem;
  logic              valid, fire;
  logic [CODE_W-1:0] pend_code, rem_code;
  logic              pend_any, rem_any;

  assign valid = (state_q == ENC_OFFER);
  assign fire  = valid & hs.ready;
  assign rise  = req & ~req_d;
  assign set   = EDGE_DETECT ? rise : req;
  assign clr   = fire ? onehot(code_q) : '0;
  // Requests arriving in the accept cycle are left out of the reload so the grant order stays stable.
  assign rem   = pending & ~clr;

  assign hs.valid = valid;
  assign hs.code  = valid ? code_q : '0;

  prio_enc8 #(.LOW_FIRST(LOW_FIRST)) u_prio_pend (
    .vec  (pending),
    .code (pend_code),
    .any  (pend_any)
  );

  prio_enc8 #(.LOW_FIRST(LOW_FIRST)) u_prio_rem (
    .vec  (rem),
    .code (rem_code),
    .any  (rem_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ENC_IDLE: begin
        if (pend_any) begin
          state_d = ENC_OFFER;
          code_d  = pend_code;
        end
      end
      ENC_OFFER: begin
        if (fire) begin
          if (rem_any) begin
            code_d = rem_code;
          end else begin
            state_d = ENC_IDLE;
            code_d  = '0;
          end
        end
      end
      default: begin
        state_d = ENC_IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENC_IDLE;
      code_q  <= '0;
      pending <= '0;
      req_d   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pending <= rem | set;
      req_d   <= req;
    end
  end

`ifdef IRQ_ENCODER_OVF_EN
  // Only rising edges count, so a held level request does not flag every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (|(rise & rem)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_irq_encoder8to3.sv
// Bench for irq_encoder8to3: two configurations driven in lockstep against a cycle-level reference model.
module tb_irq_encoder8to3;
  import enc_pkg::*;

`ifdef IRQ_ENCODER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       ready = 1'b0;
  logic [7:0] pend0, pend1;
  logic       ovf0, ovf1;

  irq_encoder8to3_if if0 ();
  irq_encoder8to3_if if1 ();
  assign if0.ready = ready;
  assign if1.ready = ready;

  irq_encoder8to3 #(.LOW_FIRST(1'b0), .EDGE_DETECT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .hs(if0), .pending(pend0), .ovf(ovf0)
  );
  irq_encoder8to3 #(.LOW_FIRST(1'b1), .EDGE_DETECT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .hs(if1), .pending(pend1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state per configuration: index 0 = high-first/level, 1 = low-first/edge.
  bit        LF [2] = '{1'b0, 1'b1};
  bit        ED [2] = '{1'b0, 1'b1};
  bit [7:0]  m_pend [2];
  bit        m_val  [2];
  int        m_code [2];
  bit        m_ovf  [2];
  bit [7:0]  m_reqd [2];

  function automatic int best(input bit [7:0] v, input bit lf);
    int b = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] && (!lf || b == 0 && !v[0] || i < b)) b = i;
    end
    if (lf) begin
      for (int i = 7; i >= 0; i--) if (v[i]) b = i;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit [7:0] r, input bit rd, input bit rs);
    bit [7:0] rise, setm, rem;
    bit       fire;
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_pend[k] = '0; m_val[k] = 1'b0; m_code[k] = 0; m_ovf[k] = 1'b0; m_reqd[k] = '0;
      end else begin
        rise = r & ~m_reqd[k];
        setm = ED[k] ? rise : r;
        fire = m_val[k] && rd;
        rem  = m_pend[k];
        if (fire) rem[m_code[k]] = 1'b0;
        if (OVF_EN && ((rise & rem) != 0)) m_ovf[k] = 1'b1;
        if (!m_val[k]) begin
          if (m_pend[k] != 0) begin
            m_val[k]  = 1'b1;
            m_code[k] = best(m_pend[k], LF[k]);
          end
        end else if (fire) begin
          if (rem != 0) m_code[k] = best(rem, LF[k]);
          else begin
            m_val[k]  = 1'b0;
            m_code[k] = 0;
          end
        end
        m_pend[k] = rem | setm;
        m_reqd[k] = r;
      end
    end
  endtask

  task automatic compare_model();
    chk("m0_valid",   {7'd0, if0.valid}, {7'd0, m_val[0]});
    chk("m0_code",    {5'd0, if0.code},  m_val[0] ? 8'(m_code[0]) : 8'd0);
    chk("m0_pending", pend0,             m_pend[0]);
    chk("m0_ovf",     {7'd0, ovf0},      {7'd0, m_ovf[0]});
    chk("m1_valid",   {7'd0, if1.valid}, {7'd0, m_val[1]});
    chk("m1_code",    {5'd0, if1.code},  m_val[1] ? 8'(m_code[1]) : 8'd0);
    chk("m1_pending", pend1,             m_pend[1]);
    chk("m1_ovf",     {7'd0, ovf1},      {7'd0, m_ovf[1]});
  endtask

  task automatic step(input bit [7:0] r, input bit rd, input bit rs = 1'b0);
    req = r; ready = rd; rst = rs;
    model_step(r, rd, rs);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  int hi_seq [4] = '{7, 5, 2, 0};
  int lo_seq [4] = '{0, 2, 5, 7};
  bit [7:0] rr;

  initial begin
    // Reset state
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("rst_valid0", {7'd0, if0.valid}, 8'd0);
    chk("rst_pend1",  pend1, 8'd0);

    // Single request: valid two edges after req, one-cycle grant
    step(8'h10, 1'b1);
    chk("single_pend0", pend0, 8'h10);
    chk("single_nv0",   {7'd0, if0.valid}, 8'd0);
    step(8'h00, 1'b1);
    chk("single_v0", {7'd0, if0.valid}, 8'd1);
    chk("single_c0", {5'd0, if0.code},  8'd4);
    chk("single_c1", {5'd0, if1.code},  8'd4);
    step(8'h00, 1'b1);
    chk("single_done0", {7'd0, if0.valid}, 8'd0);
    chk("single_pclr1", pend1, 8'd0);

    // Burst of four in both priority orders
    step(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b1);
      chk("burst_c0", {5'd0, if0.code}, 8'(hi_seq[i]));
      chk("burst_c1", {5'd0, if1.code}, 8'(lo_seq[i]));
    end
    step(8'h00, 1'b1);
    chk("burst_end0", {7'd0, if0.valid}, 8'd0);
    chk("burst_end1", {7'd0, if1.valid}, 8'd0);

    // Stall stability: a higher request does not disturb the held offer
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);
    chk("stall_c0", {5'd0, if0.code}, 8'd0);
    step(8'h80, 1'b0);
    chk("stall_hold0", {5'd0, if0.code}, 8'd0);
    chk("stall_v0",    {7'd0, if0.valid}, 8'd1);
    chk("stall_pend0", pend0, 8'h81);
    chk("stall_pend1", pend1, 8'h81);
    step(8'h00, 1'b1);
    chk("stall_next0", {5'd0, if0.code}, 8'd7);
    chk("stall_next1", {5'd0, if1.code}, 8'd7);
    step(8'h00, 1'b1);

    // Set-vs-clear collision re-pends the accepted index
    step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    chk("coll_c0", {5'd0, if0.code}, 8'd3);
    step(8'h08, 1'b1);
    chk("coll_drop0", {7'd0, if0.valid}, 8'd0);
    chk("coll_pend0", pend0, 8'h08);
    chk("coll_pend1", pend1, 8'h08);
    step(8'h00, 1'b0);
    chk("coll_again0", {5'd0, if0.code}, 8'd3);
    chk("coll_again1", {7'd0, if1.valid}, 8'd1);
    step(8'h00, 1'b1);

    // Lost-request flag: second pulse on an already-pending bit
    step(8'h04, 1'b0);
    step(8'h00, 1'b0);
    chk("ovf_pre1", {7'd0, ovf1}, 8'd0);
    step(8'h04, 1'b0);
    chk("ovf_set1", {7'd0, ovf1}, {7'd0, OVF_EN});
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    chk("ovf_sticky1", {7'd0, ovf1}, {7'd0, OVF_EN});
    chk("ovf_sticky0", {7'd0, ovf0}, {7'd0, OVF_EN});

    // Reset mid-offer discards the unaccepted code
    step(8'h10, 1'b0);
    step(8'h00, 1'b0);
    chk("rmid_c0", {5'd0, if0.code}, 8'd4);
    step(8'h00, 1'b0, 1'b1);
    chk("rmid_v0",   {7'd0, if0.valid}, 8'd0);
    chk("rmid_c0z",  {5'd0, if0.code},  8'd0);
    chk("rmid_p0",   pend0, 8'd0);
    chk("rmid_ovf1", {7'd0, ovf1}, 8'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      step(rr, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_encoder8to3.md
Name: irq_encoder8to3

Overview:
- Sequential 8-to-3 priority encoder: the encode-side counterpart of the team's one-hot 3-to-8 decode path.
- Latches eight request lines into a pending register.
- Offers the highest-priority pending index as a 3-bit code over a valid/ready handshake.
- Clears each index once it is accepted.
- Sits between peripheral request lines and a consumer that re-expands the accepted code through the 3-to-8 decoder.

Parameters:
- LOW_FIRST, 0, 0: index 7 is highest priority; 1: index 0 is highest priority.
- EDGE_DETECT, 0, 0: a request sets pending while level-high; 1: only a rising edge of the request sets pending.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  8  request lines; bit i requests index i.
- code  output  3  offered index; forced to 3'b000 when valid=0.
- valid  output  1  code is being offered.
- ready  input  1  consumer accepts; fire = valid & ready at a rising edge.
- pending  output  8  current pending register.
- ovf  output  1  sticky lost-request flag (see Optional Feature).

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port is named clk, reset port is named rst.
- Reset: on a rising edge with rst=1:
  - pending=0, state=IDLE, valid=0, code=0, ovf=0, req_d=0.
  - req is ignored during that cycle.
  - Applies mid-offer as well; an unaccepted code is discarded.
- Set mask:
  - set = req when EDGE_DETECT=0.
  - set = req & ~req_d when EDGE_DETECT=1; req_d is the one-cycle-delayed req.
- Clear mask: clr = onehot(code) on fire, else 0.
- Pending update: pending <= (pending & ~clr) | set. Set wins over clear on the same bit in the same cycle; that index is re-pended and offered again later.
- FSM with two states, IDLE and OFFER:
  - IDLE (valid=0): if pending!=0, load code = prio(pending) and go to OFFER; else stay in IDLE.
  - OFFER (valid=1) with ready=0: code and valid are held stable, even if a higher-priority request arrives.
  - OFFER on fire: rem = pending & ~clr; new sets from the same cycle are excluded. If rem!=0, load code = prio(rem) and stay in OFFER (back-to-back grants, no bubble). Else go to IDLE.
- Latency: req sampled at edge k sets pending after edge k; valid=1 with the code after edge k+1 (2 edges, from IDLE).
- prio(): the highest set index when LOW_FIRST=0, the lowest when LOW_FIRST=1. Its input is never zero when it is used.
- Level mode: a held request re-pends every cycle, so it is offered repeatedly after each accept. The requester must drop it; this is intended.
- All 8 bits set simultaneously: 8 consecutive grants in priority order while ready=1, then valid=0.
- ready while valid=0: ignored; nothing is cleared.

Optional Feature:
- Macro: IRQ_ENCODER_OVF_EN.
- Defined:
  - ovf is set (sticky until rst) when set[i]=1, pending[i]=1 and clr[i]=0 in the same cycle, i.e. a request merged into an already-pending one.
  - In level mode only rising edges of req count toward ovf, to avoid constant flagging.
- Not defined: ovf is tied to 0 and no detection logic is built.

Decomposition:
- Package enc_pkg holds:
  - N_REQ=8, CODE_W=3.
  - typedef enum {ENC_IDLE, ENC_OFFER} enc_state_t.
- Sub-module prio_enc8: combinational; inputs vec[7:0] and LOW_FIRST parameter; outputs code[2:0] and any. It is instantiated twice: once on pending (IDLE load) and once on rem (fire reload).

Test Plan:
- Reset mid-offer: req=8'h10, ready=0 until valid=1 with code=4; assert rst for 1 cycle -> next cycle valid=0, code=0, pending=0.
- Single request, LOW_FIRST=0: pulse req=8'h10 for one cycle, ready=1 -> valid rises 2 edges after req, code=4 for exactly 1 cycle, pending returns to 0.
- Burst order: one-cycle req=8'hA5 with ready=1 -> codes 7,5,2,0 on consecutive cycles, then valid=0. With LOW_FIRST=1 -> codes 0,2,5,7.
- Stall stability: req=8'h01, ready=0 holds code=0; then req=8'h80 -> code stays 0 and pending=8'h81. ready=1 -> code 0 accepted, then code=7 on the next cycle.
- Set-vs-clear collision: code=3 offered, ready=1 and req=8'h08 on the same edge -> bit 3 remains pending, valid drops for one cycle, then code=3 is offered again.
- IRQ_ENCODER_OVF_EN, EDGE_DETECT=1: pulse req bit 2 twice with ready=0 -> ovf=1 after the second pulse and stays 1 until rst. With the macro undefined, ovf stays 0.
